// File: rtl/byte_ram_io.sv
// Byte-wide RAM with a small memory-mapped IO window: a TX byte FIFO at 0x30000
// and a simulation-halt / FIFO-occupancy register at 0x30004.
module byte_ram_io #(
    parameter int unsigned ADDR_WIDTH  = 17,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        tx_overflow,
    output logic        sim_halt
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);
    // Occupancy at or above which free slots <= FULL_MARGIN.
    localparam logic [CntW-1:0] FullThresh =
        (FULL_MARGIN >= FIFO_DEPTH) ? '0 : CntW'(FIFO_DEPTH - FULL_MARGIN);
    localparam logic [17:0] TxAddr   = 18'h30000;
    localparam logic [17:0] HaltAddr = 18'h30004;

    logic [7:0] ram [0:(2**ADDR_WIDTH)-1];
    logic [7:0] fifo_mem [0:FIFO_DEPTH-1];

    logic [7:0]      mem_din_q, mem_din_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;
    logic            halt_q, halt_d;
    logic            buf_full_q, buf_full_d;

    logic                  active;
    logic                  io_sel;
    logic                  tx_hit;
    logic                  halt_hit;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  ram_we;
    logic                  push_req;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  unused_a;

    assign unused_a = ^mem_a[31:18];

    // Any write seen together with rst is discarded, as is everything while rdy is low.
    assign active    = rdy & ~rst;
    assign io_sel    = (mem_a[17:16] == 2'b11);
    assign tx_hit    = (mem_a[17:0] == TxAddr);
    assign halt_hit  = (mem_a[17:0] == HaltAddr);
    assign ram_idx   = mem_a[ADDR_WIDTH-1:0];
    assign ram_we    = active & mem_wr & ~io_sel;
    assign push_req  = active & mem_wr & io_sel & tx_hit;
    assign fifo_full = (count_q == Depth);
    assign pop       = active & tx_valid & tx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push      = push_req & (~fifo_full | pop);

    always_comb begin
        mem_din_d = 8'h00;
        if (!mem_wr) begin
            if (io_sel) begin
                mem_din_d = halt_hit ? 8'(count_q) : 8'h00;
            end else begin
                mem_din_d = ram[ram_idx];
            end
        end
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q | (push_req & fifo_full & ~pop);
        halt_d     = active & mem_wr & io_sel & halt_hit;
        buf_full_d = (count_d >= FullThresh);
    end

    // RAM is never reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= mem_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_din_q  <= 8'h00;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            halt_q     <= 1'b0;
            buf_full_q <= 1'b0;
        end else if (rdy) begin
            mem_din_q  <= mem_din_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            halt_q     <= halt_d;
            buf_full_q <= buf_full_d;
        end
    end

    assign mem_din        = mem_din_q;
    assign io_buffer_full = buf_full_q;
    assign tx_valid       = (count_q != '0);
    assign tx_data        = fifo_mem[rd_ptr_q];
    assign tx_overflow    = overflow_q;
    assign sim_halt       = halt_q;

endmodule

// File: tb/tb_byte_ram_io.sv
// Bench for byte_ram_io: directed scenarios plus randomized traffic, all checked
// against a queue/associative-array reference model.
module tb_byte_ram_io;

    localparam int Depth  = 8;
    localparam int Margin = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        tx_overflow;
    logic        sim_halt;

    always #5 clk = ~clk;

    byte_ram_io #(
        .ADDR_WIDTH (17),
        .FIFO_DEPTH (Depth),
        .FULL_MARGIN(Margin)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .mem_dout      (mem_dout),
        .mem_din       (mem_din),
        .io_buffer_full(io_buffer_full),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .tx_overflow   (tx_overflow),
        .sim_halt      (sim_halt)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model state
    logic [7:0] ram_m [int];
    logic [7:0] fifo_m [$];
    logic [7:0] exp_din   = 8'h00;
    bit         din_known = 1'b0;
    bit         exp_ovf   = 1'b0;
    bit         exp_halt  = 1'b0;
    bit         exp_full  = 1'b0;

    int unsigned pool [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit en, input logic [31:0] a, input bit w,
                              input logic [7:0] d, input bit tr);
        bit io;
        bit popping;
        int n;
        if (r) begin
            exp_din   = 8'h00;
            din_known = 1'b1;
            fifo_m.delete();
            exp_ovf   = 1'b0;
            exp_halt  = 1'b0;
            exp_full  = 1'b0;
            return;
        end
        if (!en) return;
        io      = (a[17:16] == 2'b11);
        n       = fifo_m.size();
        popping = (n != 0) && tr;
        din_known = 1'b1;
        if (w) exp_din = 8'h00;
        else if (io) exp_din = (a[17:0] == 18'h30004) ? 8'(n) : 8'h00;
        else if (ram_m.exists(int'(a[16:0]))) exp_din = ram_m[int'(a[16:0])];
        else din_known = 1'b0;
        exp_halt = w && io && (a[17:0] == 18'h30004);
        if (popping) void'(fifo_m.pop_front());
        if (w && io && (a[17:0] == 18'h30000)) begin
            if (n < Depth || popping) fifo_m.push_back(d);
            else exp_ovf = 1'b1;
        end
        if (w && !io) ram_m[int'(a[16:0])] = d;
        exp_full = (Depth - fifo_m.size()) <= Margin;
    endtask

    task automatic compare_outputs(input string tag);
        if (din_known) check_eq({tag, "/mem_din"}, 32'(mem_din), 32'(exp_din));
        check_eq({tag, "/tx_valid"}, 32'(tx_valid), 32'(fifo_m.size() != 0));
        if (fifo_m.size() != 0) check_eq({tag, "/tx_data"}, 32'(tx_data), 32'(fifo_m[0]));
        check_eq({tag, "/io_buffer_full"}, 32'(io_buffer_full), 32'(exp_full));
        check_eq({tag, "/tx_overflow"}, 32'(tx_overflow), 32'(exp_ovf));
        check_eq({tag, "/sim_halt"}, 32'(sim_halt), 32'(exp_halt));
    endtask

    task automatic step(input string tag, input bit r, input bit en, input logic [31:0] a,
                        input bit w, input logic [7:0] d, input bit tr);
        rst      = r;
        rdy      = en;
        mem_a    = a;
        mem_wr   = w;
        mem_dout = d;
        tx_ready = tr;
        model_step(r, en, a, w, d, tr);
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    initial begin
        logic [7:0] pushed [$];
        logic [31:0] a;
        logic [7:0]  d;
        bit          r, en, w, tr;
        int          sel;

        rst = 1'b1; rdy = 1'b1; mem_a = '0; mem_wr = 1'b0; mem_dout = '0; tx_ready = 1'b0;

        step("reset", 1, 1, 32'h0, 0, 8'h00, 0);
        check_eq("reset_din", 32'(mem_din), 32'h0);
        check_eq("reset_valid", 32'(tx_valid), 32'h0);

        pool = '{32'h10, 32'h100, 32'h101, 32'h102, 32'h103, 32'h1FFFF, 32'h0};
        for (int i = 0; i < 9; i++) pool.push_back(32'($urandom_range(0, 32'h1FFFF)));
        foreach (pool[i]) step("init", 0, 1, pool[i], 1, 8'($urandom), 0);

        // Write then immediate read-back
        step("wr_a5", 0, 1, 32'h10, 1, 8'hA5, 0);
        step("rd_a5", 0, 1, 32'h10, 0, 8'h00, 0);
        check_eq("a5_readback", 32'(mem_din), 32'hA5);

        // Back-to-back reads
        for (int i = 0; i < 4; i++) step("b2b_rd", 0, 1, 32'h100 + i, 0, 8'h00, 0);

        // Fill past the near-full margin, then overflow, then drain in order
        step("rst36", 1, 1, 32'h0, 0, 8'h00, 0);
        pushed.delete();
        for (int i = 0; i < 9; i++) begin
            d = 8'($urandom);
            if (i < 8) pushed.push_back(d);
            step("fill", 0, 1, 32'h30000, 1, d, 0);
            if (i == 4) check_eq("full_after5", 32'(io_buffer_full), 32'h0);
            if (i == 5) check_eq("full_after6", 32'(io_buffer_full), 32'h1);
            if (i == 7) check_eq("ovf_after8", 32'(tx_overflow), 32'h0);
        end
        check_eq("ovf_after9", 32'(tx_overflow), 32'h1);
        step("cnt8", 0, 1, 32'h30004, 0, 8'h00, 0);
        check_eq("count_eq8", 32'(mem_din), 32'h8);
        for (int i = 0; i < 8; i++) begin
            check_eq("drain_order", 32'(tx_data), 32'(pushed[i]));
            step("drain", 0, 1, 32'h100, 0, 8'h00, 1);
        end
        check_eq("drained_empty", 32'(tx_valid), 32'h0);

        // Full FIFO: push and pop in the same cycle
        step("rst37", 1, 1, 32'h0, 0, 8'h00, 0);
        for (int i = 0; i < 8; i++) step("fill37", 0, 1, 32'h30000, 1, 8'hC0 + 8'(i), 0);
        step("push_pop_full", 0, 1, 32'h30000, 1, 8'h55, 1);
        check_eq("ovf_pushpop", 32'(tx_overflow), 32'h0);
        step("cnt_pushpop", 0, 1, 32'h30004, 0, 8'h00, 0);
        check_eq("count_pushpop", 32'(mem_din), 32'h8);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check_eq("last_out_55", 32'(tx_data), 32'h55);
            step("drain37", 0, 1, 32'h101, 0, 8'h00, 1);
        end

        // Empty FIFO: push and pop together still accepts the push
        step("push_pop_empty", 0, 1, 32'h30000, 1, 8'h77, 1);
        check_eq("count_empty_pp", 32'(tx_valid), 32'h1);
        step("pop77", 0, 1, 32'h101, 0, 8'h00, 1);

        // Halt pulse and occupancy read
        step("halt", 0, 1, 32'h30004, 1, 8'h00, 0);
        check_eq("halt_hi", 32'(sim_halt), 32'h1);
        step("halt_lo", 0, 1, 32'h100, 0, 8'h00, 0);
        check_eq("halt_lo", 32'(sim_halt), 32'h0);
        for (int i = 0; i < 3; i++) step("q3", 0, 1, 32'h30000, 1, 8'(i + 1), 0);
        step("rd_cnt3", 0, 1, 32'h30004, 0, 8'h00, 0);
        check_eq("count_eq3", 32'(mem_din), 32'h3);

        // rdy low freezes state
        step("frozen", 0, 0, 32'h30000, 1, 8'hEE, 1);
        step("rd_cnt_frz", 0, 1, 32'h30004, 0, 8'h00, 0);
        check_eq("count_frozen", 32'(mem_din), 32'h3);

        // Reset with rdy low and a RAM write in flight
        step("q4", 0, 1, 32'h30000, 1, 8'h04, 0);
        step("rst_rdy0", 1, 0, 32'h10, 1, 8'h3C, 0);
        check_eq("rst_valid", 32'(tx_valid), 32'h0);
        check_eq("rst_din", 32'(mem_din), 32'h0);
        step("rst_push", 1, 1, 32'h30000, 1, 8'h99, 1);
        step("ram_kept", 0, 1, 32'h10, 0, 8'h00, 0);
        check_eq("ram_survives", 32'(mem_din), 32'hA5);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 63) == 0);
            en = ($urandom_range(0, 7) != 0);
            if (((i / 100) % 2) == 0) tr = ($urandom_range(0, 3) == 0);
            else tr = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 9);
            d   = 8'($urandom);
            w   = 1'b0;
            a   = pool[$urandom_range(0, pool.size() - 1)];
            case (sel)
                3:       w = 1'b1;
                4, 5, 6: begin a = 32'h30000; w = 1'b1; end
                7:       begin a = 32'h30004; w = 1'b1; end
                8:       a = 32'h30004;
                9:       begin a = ($urandom_range(0, 1) != 0) ? 32'h30008 : 32'h3000C;
                               w = ($urandom_range(0, 1) != 0); end
                default: ;
            endcase
            step("rand", r, en, a, w, d, tr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_ram_io.md
BYTE_RAM_IO -- requirements
Module: byte_ram_io

Interface
REQ-001 Parameter ADDR_WIDTH, default 17, SHALL set the RAM index width (2^ADDR_WIDTH bytes).
REQ-002 Parameter FIFO_DEPTH, default 8, SHALL set the TX FIFO depth (power of two, >=4).
REQ-003 Parameter FULL_MARGIN, default 2, SHALL set the free-slot count at or below which io_buffer_full asserts.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 rdy  in  1  global enable; low freezes all state.
REQ-007 mem_a  in  32  byte address from the memory controller.
REQ-008 mem_wr  in  1  1 = write, 0 = read.
REQ-009 mem_dout  in  8  write data driven by the controller.
REQ-010 mem_din  out  8  registered read data to the controller.
REQ-011 io_buffer_full  out  1  TX FIFO near-full back-pressure to the controller.
REQ-012 tx_valid  out  1  TX FIFO head valid.
REQ-013 tx_data  out  8  TX FIFO head byte.
REQ-014 tx_ready  in  1  downstream byte sink accepts head.
REQ-015 tx_overflow  out  1  sticky flag: a push was dropped.
REQ-016 sim_halt  out  1  one-cycle pulse on halt write.

Function
REQ-017 Address decode: mem_a[17:16]==2'b11 SHALL select IO space; all other addresses SHALL select RAM at index mem_a[ADDR_WIDTH-1:0].
REQ-018 RAM read: mem_din SHALL present ram[mem_a] exactly one cycle after mem_a is sampled with mem_wr=0 (1-cycle latency, back-to-back reads every cycle).
REQ-019 RAM write: mem_wr=1 SHALL write mem_dout to ram[mem_a] at that posedge; mem_din SHALL load 8'h00 that cycle.
REQ-020 Read-after-write to the same address on the next cycle SHALL return the newly written byte.
REQ-021 IO write 0x30000 SHALL push mem_dout into the TX FIFO.
REQ-022 IO write 0x30004 SHALL pulse sim_halt for one cycle; no FIFO change.
REQ-023 IO read 0x30004 SHALL return the FIFO occupancy count (zero-extended) one cycle later; any other IO read SHALL return 8'h00; IO writes to other addresses SHALL be ignored.
REQ-024 FIFO pop SHALL occur on a posedge with tx_valid && tx_ready; tx_data SHALL equal the head byte combinationally.
REQ-025 Order SHALL be strict FIFO; pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-026 Simultaneous push and pop SHALL leave count unchanged, including when full (pop frees the slot for the push) and when empty (push accepted, count 1 after).
REQ-027 Push when full without simultaneous pop SHALL be dropped and set tx_overflow, held until reset.
REQ-028 io_buffer_full SHALL be registered and equal (FIFO_DEPTH - next_count) <= FULL_MARGIN.
REQ-029 tx_valid SHALL equal count != 0.
REQ-030 rdy=0 SHALL suppress RAM writes, pushes, pops, and sim_halt; mem_din, count, pointers, and flags SHALL hold.

Reset
REQ-031 rst=1 SHALL clear mem_din, count, pointers, tx_overflow, sim_halt, and io_buffer_full to 0 on the next posedge, regardless of rdy or an in-flight access.
REQ-032 RAM contents SHALL NOT be cleared by reset.
REQ-033 A write presented in the same cycle as rst=1 SHALL be discarded (no RAM write, no push).

Verification
REQ-034 Write 0xA5 to 0x00010, then read 0x00010 on the next cycle -> mem_din = 0xA5 one cycle after the read.
REQ-035 Reads at 0x100..0x103 on four consecutive cycles -> mem_din shows bytes 0x100..0x103 on the following four cycles.
REQ-036 tx_ready=0; push 6 bytes via 0x30000 -> io_buffer_full=1 after the 6th push (FIFO_DEPTH=8, FULL_MARGIN=2); push 3 more -> count=8, tx_overflow=1; tx_ready=1 -> first 8 bytes drain in order.
REQ-037 FIFO full with tx_ready=1, push 0x55 in the same cycle -> count stays 8, 0x55 is last out, tx_overflow unchanged.
REQ-038 Write to 0x30004 -> sim_halt high for exactly one cycle; read 0x30004 with 3 queued bytes -> mem_din = 0x03.
REQ-039 Assert rst with 4 bytes queued and rdy=0 -> count=0, tx_valid=0, mem_din=0 next cycle; previously written RAM byte still reads back.
